viterbi_top: RTL and testbench

//  Log-domain (max-plus) Viterbi decoder for a discrete HMM with I states and K symbols.

---
 rtl/viterbi_top.sv | 153 +++++++++++++++
 tb/tb_viterbi_top.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_top.sv
// Max-plus Viterbi decoder: runs the forward recursion one observation per accepted cycle,
// then backtracks one path entry per cycle into a registered parallel path array.
module viterbi_top #(
  parameter int N = 8,
  parameter int I = 3,
  parameter int K = 3,
  parameter int W = 20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(N)-1:0]         length,
  input  logic [$clog2(K)-1:0]         obs_in,
  input  logic                         obs_valid,
  input  logic signed [W-1:0]          logA [I*I],
  input  logic signed [W-1:0]          logC [I],
  input  logic signed [W-1:0]          logB [I*K],
  output logic [$clog2(I)-1:0]         path [N],
  output logic                         done,
  output logic                         valid_out
);

  localparam int LW = $clog2(N);
  localparam int SW = $clog2(I);
  localparam int KW = $clog2(K);
  localparam int BW = $clog2(I*K);
  localparam int XW = W + 2;

  typedef enum logic [1:0] {IDLE, RUN, TRACE, DONE} state_t;

  state_t              state, state_next;
  logic [LW-1:0]       t, len, tk;
  logic [LW-1:0]       len_start, cur_len, t_eff, trace_pos, trace_t;
  logic [SW-1:0]       cur, final_idx, trace_idx;
  logic signed [W-1:0] delta      [I];
  logic signed [W-1:0] delta_next [I];
  logic [SW-1:0]       bp         [N][I];
  logic [SW-1:0]       bp_next    [I];
  logic signed [W-1:0] fbest;
  logic signed [XW-1:0] cand, best;
  logic [BW-1:0]       bidx;
  logic [KW-1:0]       obs_sel;
  logic                accept_start, consume, last_obs;

  function automatic logic signed [W-1:0] sat(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] maxv, minv;
    maxv = {3'b000, {(W-1){1'b1}}};
    minv = {3'b111, {(W-1){1'b0}}};
    if (v > maxv)      return {1'b0, {(W-1){1'b1}}};
    else if (v < minv) return {1'b1, {(W-1){1'b0}}};
    else               return v[W-1:0];
  endfunction

  // Handshake: obs_in is taken on every rising edge where obs_valid is high and the decoder
  // is in RUN (or is accepting start in the same cycle); there is no ready/backpressure.
  always_comb begin
    accept_start = (state == IDLE || state == DONE) && start;
    len_start    = (length == '0) ? LW'(1) : length;
    cur_len      = accept_start ? len_start : len;
    t_eff        = accept_start ? '0 : t;
    consume      = obs_valid && (accept_start || state == RUN);
    last_obs     = consume && (t_eff == cur_len - LW'(1));
    obs_sel      = (int'(obs_in) < K) ? obs_in : '0;
  end

  // Add-compare-select for every destination state; strict > keeps the lowest index on ties.
  always_comb begin
    cand = '0;
    best = '0;
    bidx = '0;
    for (int j = 0; j < I; j++) begin
      best       = XW'(delta[0]) + XW'(logA[j]);
      bp_next[j] = '0;
      for (int i = 1; i < I; i++) begin
        cand = XW'(delta[i]) + XW'(logA[i*I+j]);
        if (cand > best) begin
          best       = cand;
          bp_next[j] = SW'(i);
        end
      end
      if (t_eff == '0) best = XW'(logC[j]);
      bidx          = BW'(j*K) + BW'(obs_sel);
      delta_next[j] = sat(best + XW'(logB[bidx]));
    end
  end

  always_comb begin
    final_idx = '0;
    fbest     = delta[0];
    for (int j = 1; j < I; j++) begin
      if (delta[j] > fbest) begin
        fbest     = delta[j];
        final_idx = SW'(j);
      end
    end
    trace_pos = len - LW'(1) - tk;
    trace_t   = len - tk;
    trace_idx = (tk == '0) ? final_idx : bp[trace_t][cur];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept_start)       state_next = last_obs ? TRACE : RUN;
        else if (state == DONE) state_next = IDLE;
      end
      RUN:     if (last_obs) state_next = TRACE;
      TRACE:   if (tk == len - LW'(1)) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      t         <= '0;
      len       <= '0;
      tk        <= '0;
      cur       <= '0;
      done      <= 1'b0;
      valid_out <= 1'b0;
      for (int j = 0; j < I; j++) delta[j] <= '0;
      for (int n = 0; n < N; n++) begin
        path[n] <= '0;
        for (int j = 0; j < I; j++) bp[n][j] <= '0;
      end
    end else begin
      state     <= state_next;
      done      <= (state_next == DONE);
      valid_out <= (state_next == DONE) && (state != DONE);
      if (accept_start) begin
        len <= len_start;
        t   <= '0;
        tk  <= '0;
        for (int n = 0; n < N; n++) path[n] <= '0;
      end
      if (consume) begin
        for (int j = 0; j < I; j++) delta[j] <= delta_next[j];
        if (t_eff != '0) begin
          for (int j = 0; j < I; j++) bp[t_eff][j] <= bp_next[j];
        end
        t <= t_eff + LW'(1);
      end
      if (state == TRACE) begin
        path[trace_pos] <= trace_idx;
        cur             <= trace_idx;
        tk              <= tk + LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_viterbi_top.sv
// Bench for viterbi_top: directed HMM vectors plus randomised decodes, with expected
// paths queued at stimulus time and compared whenever valid_out pulses.
module tb_viterbi_top;
  localparam int N  = 8;
  localparam int I  = 3;
  localparam int K  = 3;
  localparam int W  = 20;
  localparam int LW = $clog2(N);
  localparam int SW = $clog2(I);
  localparam int KW = $clog2(K);
  localparam int PW = N * SW;

  logic                clk, rst_n, start, obs_valid, done, valid_out;
  logic [LW-1:0]       length;
  logic [KW-1:0]       obs_in;
  logic signed [W-1:0] logA [I*I];
  logic signed [W-1:0] logC [I];
  logic signed [W-1:0] logB [I*K];
  logic [SW-1:0]       path [N];

  int tests, fails, pulses, decodes;
  logic [PW-1:0] exp_q[$];
  int obs_v[N];
  logic prev_vo;

  viterbi_top #(.N(N), .I(I), .K(K), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .length(length), .obs_in(obs_in),
    .obs_valid(obs_valid), .logA(logA), .logC(logC), .logB(logB),
    .path(path), .done(done), .valid_out(valid_out)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] packed_path();
    logic [PW-1:0] r;
    for (int k = 0; k < N; k++) r[k*SW +: SW] = path[k];
    return r;
  endfunction

  function automatic longint satl(input longint v);
    longint mx, mn;
    mx = (longint'(1) <<< (W-1)) - 1;
    mn = -(longint'(1) <<< (W-1));
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  // reference Viterbi over obs_v[0..n-1] using the current tables
  function automatic logic [PW-1:0] model(input int n);
    longint d[I], nd[I];
    int bpm[N][I];
    int p[N];
    int m;
    longint best, c;
    logic [PW-1:0] r;
    m = (n == 0) ? 1 : n;
    for (int j = 0; j < I; j++) d[j] = satl(longint'(logC[j]) + longint'(logB[j*K+obs_v[0]]));
    for (int t = 1; t < m; t++) begin
      for (int j = 0; j < I; j++) begin
        best = d[0] + longint'(logA[j]);
        bpm[t][j] = 0;
        for (int i = 1; i < I; i++) begin
          c = d[i] + longint'(logA[i*I+j]);
          if (c > best) begin best = c; bpm[t][j] = i; end
        end
        nd[j] = satl(best + longint'(logB[j*K+obs_v[t]]));
      end
      for (int j = 0; j < I; j++) d[j] = nd[j];
    end
    p[m-1] = 0;
    best = d[0];
    for (int j = 1; j < I; j++) if (d[j] > best) begin best = d[j]; p[m-1] = j; end
    for (int t = m - 1; t > 0; t--) p[t-1] = bpm[t][p[t]];
    r = '0;
    for (int k = 0; k < m; k++) r[k*SW +: SW] = SW'(p[k]);
    return r;
  endfunction

  task automatic set_std();
    for (int i = 0; i < I; i++) begin
      for (int j = 0; j < I; j++)
        logA[i*I+j] = W'((i == j) ? -10 : ((j == (i + 1) % I) ? -50 : -100));
      logC[i] = W'((i == 0) ? -10 : -50);
      for (int s = 0; s < K; s++) logB[i*K+s] = W'((i == s) ? -5 : -100);
    end
  endtask

  task automatic set_all(input int v);
    for (int k = 0; k < I*I; k++) logA[k] = W'(v);
    for (int k = 0; k < I; k++)   logC[k] = W'(v);
    for (int k = 0; k < I*K; k++) logB[k] = W'(v);
  endtask

  function automatic int pick(input bit extreme);
    int sel;
    if (!extreme) return -int'($urandom_range(0, 60));
    sel = int'($urandom_range(0, 3));
    case (sel)
      0: return -(1 <<< (W-1));
      1: return (1 <<< (W-1)) - 1;
      2: return 0;
      default: return -int'($urandom_range(0, 5));
    endcase
  endfunction

  task automatic set_rand(input bit extreme);
    for (int k = 0; k < I*I; k++) logA[k] = W'(pick(extreme));
    for (int k = 0; k < I; k++)   logC[k] = W'(pick(extreme));
    for (int k = 0; k < I*K; k++) logB[k] = W'(pick(extreme));
  endtask

  task automatic set_obs5(input int a, input int b, input int c, input int d, input int e);
    obs_v[0] = a; obs_v[1] = b; obs_v[2] = c; obs_v[3] = d; obs_v[4] = e;
  endtask

  // driver: one full decode; b2b issues start while the decoder still sits in DONE
  task automatic run_decode(input int n, input bit gaps, input bit b2b, input bit mid_start,
                            input logic [PW-1:0] expv);
    int cyc;
    int lenf;
    lenf = (n == 0) ? 1 : n;
    if (b2b) check("done_level", done, 1);
    else begin @(posedge clk); #1; end
    exp_q.push_back(expv);
    decodes++;
    start = 1'b1; length = LW'(n); obs_valid = 1'b1; obs_in = KW'(obs_v[0]);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < lenf; k++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        obs_valid = 1'b0;
        obs_in    = KW'($urandom_range(0, K - 1));
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        check("t_frozen", 32'(dut.t), k);
      end
      if (mid_start && k == 2) begin start = 1'b1; length = LW'(1); end
      obs_valid = 1'b1; obs_in = KW'(obs_v[k]);
      @(posedge clk); #1;
      start = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 40) begin
      obs_valid = 1'($urandom_range(0, 1));
      obs_in    = KW'($urandom_range(0, K - 1));
      @(posedge clk); #1;
      cyc++;
    end
    obs_valid = 1'b0;
    check("latency", cyc, lenf);
    @(negedge clk); #1;
  endtask

  // scoreboard: compare against the queue on every valid_out pulse
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out) begin
        pulses++;
        check("vo_single", 32'(prev_vo), 0);
        check("done_with_vo", 32'(done), 1);
        if (exp_q.size() == 0) check("unexpected_vo", 1, 0);
        else check("path", 32'(packed_path()), 32'(exp_q.pop_front()));
      end
      prev_vo = valid_out;
    end else begin
      prev_vo = 1'b0;
    end
  end

  initial begin
    tests = 0; fails = 0; pulses = 0; decodes = 0; prev_vo = 1'b0;
    rst_n = 1'b0; start = 1'b0; obs_valid = 1'b0; length = '0; obs_in = '0;
    for (int k = 0; k < N; k++) obs_v[k] = 0;
    set_std();
    #12;
    check("rst_state", 32'(dut.state), 0);
    check("rst_t", 32'(dut.t), 0);
    check("rst_done", 32'(done), 0);
    check("rst_vo", 32'(valid_out), 0);
    check("rst_path", 32'(packed_path()), 0);
    rst_n = 1'b1;

    set_obs5(0, 0, 1, 1, 2);
    run_decode(5, 1'b0, 1'b0, 1'b0, PW'(16'h0250));
    obs_v[0] = 0; obs_v[1] = 0; obs_v[2] = 0;
    run_decode(3, 1'b0, 1'b1, 1'b0, PW'(16'h0000));
    set_obs5(0, 0, 1, 1, 2);
    run_decode(5, 1'b1, 1'b0, 1'b0, PW'(16'h0250));
    run_decode(5, 1'b0, 1'b0, 1'b1, PW'(16'h0250));

    set_all(-7);
    set_obs5(2, 1, 0, 2, 0);
    run_decode(4, 1'b0, 1'b0, 1'b0, PW'(16'h0000));

    // asynchronous reset in the middle of RUN
    set_std();
    set_obs5(0, 0, 1, 1, 2);
    @(posedge clk); #1;
    start = 1'b1; length = LW'(5); obs_valid = 1'b1; obs_in = KW'(0);
    repeat (3) begin @(posedge clk); #1; start = 1'b0; end
    obs_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("mid_rst_state", 32'(dut.state), 0);
    check("mid_rst_t", 32'(dut.t), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_path", 32'(packed_path()), 0);
    rst_n = 1'b1;
    run_decode(5, 1'b0, 1'b0, 1'b0, PW'(16'h0250));

    obs_v[0] = 1;
    run_decode(0, 1'b0, 1'b0, 1'b0, PW'(16'h0001));
    obs_v[0] = 0; obs_v[1] = 1; obs_v[2] = 2; obs_v[3] = 0;
    obs_v[4] = 1; obs_v[5] = 2; obs_v[6] = 0;
    run_decode(7, 1'b1, 1'b1, 1'b0, model(7));

    for (int r = 0; r < 14; r++) begin
      int n;
      n = int'($urandom_range(1, N - 1));
      set_rand(r % 3 == 2);
      for (int k = 0; k < N; k++) obs_v[k] = int'($urandom_range(0, K - 1));
      run_decode(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), model(n));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    check("pulse_count", pulses, decodes);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
